// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: issues one line read on a miss and streams the
// returned 64-bit beats into the cache. ICACHE_REFILL_CRITICAL_FIRST_EN selects critical-word-first ordering.
module icache_refill #(
  parameter int LINE_WORDS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        miss_req,
  input  logic [31:0] miss_addr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic        write_ff,
  output logic [31:0] write_addr_ff,
  output logic [63:0] write_data_ff,
  output logic        refill_busy,
  output logic        refill_done
);

  localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t        state;
  logic [CW-1:0] beat;
  logic          word_idx;
  logic [31:0]   req_addr_next;
  logic          unused_addr_bits;

`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
  // The request address keeps the missed word in bit 3, so beats start there and wrap.
  assign req_addr_next    = {miss_addr[31:3], 3'b000};
  assign word_idx         = mem_req_addr[3] ^ beat[0];
  assign unused_addr_bits = ^miss_addr[2:0];
`else
  assign req_addr_next    = {miss_addr[31:4], 4'b0000};
  assign word_idx         = beat[0];
  assign unused_addr_bits = ^miss_addr[3:0];
`endif

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      beat          <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      write_ff      <= 1'b0;
      write_addr_ff <= '0;
      write_data_ff <= '0;
      refill_busy   <= 1'b0;
      refill_done   <= 1'b0;
    end else begin
      // Strobes default low so each assertion below lasts exactly one cycle.
      write_ff    <= 1'b0;
      refill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_req) begin
            mem_req_addr  <= req_addr_next;
            mem_req_valid <= 1'b1;
            refill_busy   <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            beat          <= '0;
            state         <= FILL;
          end
        end
        FILL: begin
          if (mem_resp_valid) begin
            write_ff      <= 1'b1;
            write_addr_ff <= {mem_req_addr[31:4], word_idx, 3'b000};
            write_data_ff <= mem_resp_data;
            beat          <= beat + CW'(1);
            if (beat == CW'(LINE_WORDS - 1)) state <= DONE;
          end
        end
        DONE: begin
          refill_done <= 1'b1;
          refill_busy <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
